// File: rtl/clock_display_driver_pkg.sv
// Shared definitions for the clock display path: bit-width helper, 7-segment
// decode, and the converter state encoding.
package def;

  function automatic int numofbits(input int value);
    int n;
    n = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_e;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes leave the digit dark.
  function automatic logic [6:0] seg7(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/clock_display_driver_if.sv
// Time values and blink control in, multiplexed 7-segment drive out.
interface clock_display_driver_if;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_imp;
  logic [1:0] blink_sel;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  modport master (
    output hours, minutes, seconds, sec_imp, blink_sel,
    input  seg, dp, an
  );

  modport slave (
    input  hours, minutes, seconds, sec_imp, blink_sel,
    output seg, dp, an
  );
endinterface

// File: rtl/clock_display_driver_bin2bcd6.sv
// One 6-bit binary to two-digit BCD shift-add-3 lane; the parent FSM
// sequences load and the six step cycles.
module bin2bcd6 (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [5:0] bin_in,
  output logic [7:0] bcd
);

  logic [5:0] bin_q, bin_d;
  logic [7:0] bcd_q, bcd_d;
  logic [7:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;

    bin_d = bin_q;
    bcd_d = bcd_q;
    if (load) begin
      bin_d = bin_in;
      bcd_d = '0;
    end else if (step) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/clock_display_driver.sv
// Snapshots hh:mm:ss, converts to BCD with a free-running 8-cycle sequencer,
// and scans six common-anode digits with field blink and colon flash.
module clock_display_driver
  import def::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                   clock,
  input  logic                   reset,
  clock_display_driver_if.slave  bus
);

  localparam int SCAN_W  = numofbits(SCAN_DIV - 1);
  localparam int BLINK_W = numofbits(BLINK_DIV - 1);

  conv_state_e state_q;
  logic [2:0]  shift_cnt_q;
  logic        load, step, commit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE:   state_q <= LOAD;
        LOAD: begin
          shift_cnt_q <= '0;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          shift_cnt_q <= shift_cnt_q + 3'd1;
          if (shift_cnt_q == 3'd5) state_q <= COMMIT;
        end
        COMMIT: state_q <= LOAD;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load   = (state_q == LOAD);
  assign step   = (state_q == SHIFT);
  assign commit = (state_q == COMMIT);

  logic [7:0] hr_bcd, min_bcd, sec_bcd;

  bin2bcd6 u_hr  (.clock(clock), .reset(reset), .load(load), .step(step), .bin_in(bus.hours),   .bcd(hr_bcd));
  bin2bcd6 u_min (.clock(clock), .reset(reset), .load(load), .step(step), .bin_in(bus.minutes), .bcd(min_bcd));
  bin2bcd6 u_sec (.clock(clock), .reset(reset), .load(load), .step(step), .bin_in(bus.seconds), .bcd(sec_bcd));

  logic [5:0][3:0]    disp_q, disp_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               colon_phase_q, colon_phase_d;
  logic [6:0]         seg_q, seg_d;
  logic [5:0]         an_q, an_d;
  logic               dp_q, dp_d;
  logic               scan_wrap, blink_wrap, blanked;
  logic [1:0]         digit_field;

  always_comb begin
    disp_d = commit ? {hr_bcd, min_bcd, sec_bcd} : disp_q;

    scan_wrap   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_idx_d = digit_idx_q;
    if (scan_wrap) digit_idx_d = (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;

    blink_wrap    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap;
    colon_phase_d = colon_phase_q ^ bus.sec_imp;

    // Field numbering matches blink_sel: 1 hours, 2 minutes, 3 seconds.
    case (digit_idx_q)
      3'd0, 3'd1: digit_field = 2'd3;
      3'd2, 3'd3: digit_field = 2'd2;
      default:    digit_field = 2'd1;
    endcase
    blanked = blink_phase_q && (bus.blink_sel != 2'd0) && (digit_field == bus.blink_sel);

    an_d  = blanked ? 6'h3F : ~(6'b000001 << digit_idx_q);
    seg_d = blanked ? SEG_BLANK : seg7(disp_q[digit_idx_q]);
    dp_d  = !(colon_phase_q && ((digit_idx_q == 3'd2) || (digit_idx_q == 3'd4)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_q        <= '0;
      scan_cnt_q    <= '0;
      digit_idx_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      colon_phase_q <= 1'b0;
      seg_q         <= SEG_BLANK;
      an_q          <= 6'h3F;
      dp_q          <= 1'b1;
    end else begin
      disp_q        <= disp_d;
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      colon_phase_q <= colon_phase_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver: scoreboard of expected digit
// segments plus a cycle model of scan, blink and colon timing.
module tb_clock_display_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   edgeCnt = 0;
  int   errors = 0;
  int   checks = 0;
  logic expColon = 1'b0;

  typedef struct {
    int         idx;
    logic [6:0] seg;
    logic       dp;
  } sb_entry_t;

  sb_entry_t sbQ[$];

  clock_display_driver_if bus ();

  clock_display_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  // Counts active edges since reset release, mirroring when the DUT counters run.
  always @(posedge clock) begin
    if (!reset) edgeCnt <= 0;
    else        edgeCnt <= edgeCnt + 1;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] tbSeg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int expDigit(input int idx, input int h, input int m, input int s);
    case (idx)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      3: return m / 10;
      4: return h % 10;
      default: return h / 10;
    endcase
  endfunction

  // Outputs seen at the negedge after edge n reflect counter state after n-1 edges.
  function automatic int expIdx(input int n);
    return ((n - 1) / SCAN_DIV) % 6;
  endfunction

  function automatic logic [5:0] expAn(input int n, input int sel);
    int i;
    logic [5:0] one;
    logic phase;
    one   = 6'b000001;
    i     = expIdx(n);
    phase = (((n - 1) / BLINK_DIV) % 2) == 1;
    if (phase && sel != 0 && (3 - i / 2) == sel) return 6'h3F;
    return ~(one << i);
  endfunction

  function automatic logic expDp(input int n);
    int i;
    i = expIdx(n);
    return !(expColon && (i == 2 || i == 4));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int h, input int m, input int s, input int sel);
    @(negedge clock);
    bus.hours     = 6'(h);
    bus.minutes   = 6'(m);
    bus.seconds   = 6'(s);
    bus.blink_sel = 2'(sel);
  endtask

  task automatic pushDigit(input int idx, input int d);
    sb_entry_t e;
    e.idx = idx;
    e.seg = tbSeg(d);
    e.dp  = !(expColon && (idx == 2 || idx == 4));
    sbQ.push_back(e);
  endtask

  task automatic pushTime(input int h, input int m, input int s);
    for (int i = 0; i < 6; i++) pushDigit(i, expDigit(i, h, m, s));
  endtask

  task automatic drainScoreboard(input string tag);
    sb_entry_t  e;
    logic [5:0] target;
    logic [5:0] one;
    one = 6'b000001;
    while (sbQ.size() > 0) begin
      e      = sbQ.pop_front();
      target = ~(one << e.idx);
      for (int k = 0; k < 60; k++) begin
        @(negedge clock);
        if (bus.an === target) break;
      end
      checkOutput({tag, "-an"}, bus.an, target);
      checkOutput({tag, "-seg"}, bus.seg, e.seg);
      checkOutput({tag, "-dp"}, bus.dp, e.dp);
    end
  endtask

  task automatic waitPhase(input int modulus, input int rem);
    for (int k = 0; k < 200; k++) begin
      if (edgeCnt % modulus == rem) break;
      @(negedge clock);
    end
    checkOutput("sync", edgeCnt % modulus, rem);
  endtask

  initial begin
    int base;
    int mExp;
    bus.sec_imp = 1'b0;

    // Reset state, then first conversion of 23:59:45.
    applyStimulus(23, 59, 45, 0);
    repeat (3) @(negedge clock);
    checkOutput("rst-seg", bus.seg, 7'h7F);
    checkOutput("rst-an", bus.an, 6'h3F);
    checkOutput("rst-dp", bus.dp, 1'b1);
    reset = 1'b1;
    pushTime(23, 59, 45);
    repeat (16) @(negedge clock);
    drainScoreboard("conv");

    // Scan order over two full rounds with an all-zero display.
    applyStimulus(0, 0, 0, 0);
    repeat (20) @(negedge clock);
    waitPhase(SCAN_DIV * 6, 1);
    for (int c = 0; c < SCAN_DIV * 12; c++) begin
      checkOutput("scan-an", bus.an, expAn(edgeCnt, 0));
      checkOutput("scan-seg", bus.seg, 7'b1000000);
      @(negedge clock);
    end

    // Full seconds range, including out-of-clock values up to 63.
    for (int v = 0; v < 64; v++) begin
      applyStimulus(0, 0, v, 0);
      pushDigit(0, v % 10);
      pushDigit(1, v / 10);
      repeat (17) @(negedge clock);
      drainScoreboard("sweep");
    end

    // Minutes change while the previous snapshot is still shifting.
    applyStimulus(5, 10, 30, 0);
    repeat (20) @(negedge clock);
    waitPhase(24, 3);
    base = edgeCnt - 3;
    bus.minutes = 6'd11;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      mExp = (edgeCnt - base < 18) ? 10 : 11;
      checkOutput("midconv-an", bus.an, expAn(edgeCnt, 0));
      checkOutput("midconv-seg", bus.seg, tbSeg(expDigit(expIdx(edgeCnt), 5, mExp, 30)));
    end

    // Blink of each field selection, including none.
    for (int sel = 0; sel < 4; sel++) begin
      applyStimulus(5, 11, 30, sel);
      for (int c = 0; c < 48; c++) begin
        @(negedge clock);
        checkOutput($sformatf("blink%0d-an", sel), bus.an, expAn(edgeCnt, sel));
      end
    end

    // Colon pulses aligned with a blink wrap so both toggles coincide.
    applyStimulus(5, 11, 30, 2);
    for (int p = 0; p < 3; p++) begin
      waitPhase(BLINK_DIV, BLINK_DIV - 1);
      bus.sec_imp = 1'b1;
      @(negedge clock);
      bus.sec_imp = 1'b0;
      expColon = ~expColon;
      for (int c = 0; c < 24; c++) begin
        @(negedge clock);
        checkOutput($sformatf("colon%0d-dp", p), bus.dp, expDp(edgeCnt));
        checkOutput($sformatf("colon%0d-an", p), bus.an, expAn(edgeCnt, 2));
      end
    end

    // Reset pulsed during SHIFT: everything clears and the display reads 0
    // until the first post-reset commit.
    applyStimulus(5, 11, 30, 0);
    repeat (10) @(negedge clock);
    waitPhase(8, 4);
    reset = 1'b0;
    #1;
    checkOutput("midrst-seg", bus.seg, 7'h7F);
    checkOutput("midrst-an", bus.an, 6'h3F);
    checkOutput("midrst-dp", bus.dp, 1'b1);
    expColon = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      checkOutput("midrst-zero-seg", bus.seg, 7'b1000000);
      checkOutput("midrst-zero-an", bus.an, expAn(edgeCnt, 0));
    end
    pushTime(5, 11, 30);
    drainScoreboard("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
